// File: rtl/jtkcpu_pshpul_if.sv
// Byte-wide memory bus between the PSH/PUL sequencer (master) and the memory system (slave).
interface jtkcpu_pshpul_if;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        we;
    logic        rd;
    logic        bus_ok;

    modport master (output addr, dout, we, rd, input din, bus_ok);
    modport slave  (input addr, dout, we, rd, output din, bus_ok);
endinterface

// File: rtl/jtkcpu_pshpul.sv
// PSH/PUL multi-register stack sequencer: walks the postbyte mask and moves registers over a byte bus.
// Optional macro JTKCPU_PSHPUL_CNT_EN adds o_xfer_cnt (bytes completed in the current/last operation).
module jtkcpu_pshpul #(
    parameter int BUS_TO = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    jtkcpu_pshpul_if.master        bus,
    input  logic                   i_start,
    input  logic                   i_pull,
    input  logic                   i_stk_u,
    input  logic [7:0]             i_postbyte,
    input  logic [15:0]            i_sp_in,
    output logic [3:0]             o_reg_sel,
    input  logic [15:0]            i_reg_din,
    output logic [15:0]            o_wr_data,
    output logic                   o_wr_en,
    output logic [15:0]            o_sp_out,
    output logic                   o_sp_we,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
`ifdef JTKCPU_PSHPUL_CNT_EN
    ,
    output logic [3:0]             o_xfer_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_NEXT, S_LO, S_HI, S_B8, S_WB, S_FIN} state_t;

    localparam logic [15:0] TO_LAST = 16'(BUS_TO - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_mask;
    logic        r_pull, r_stk_u;
    logic [15:0] r_sp;
    logic [3:0]  r_sel;
    logic [7:0]  r_hi, r_lo;
    logic [15:0] r_wait;
    logic        r_err;
    logic [2:0]  w_idx;
    logic [3:0]  w_code;
    logic        w_empty, w_bus_st, w_byte_done, w_timeout;

    // Push walks from bit 7 down, pull from bit 0 up.
    function automatic logic [2:0] f_pick(input logic [7:0] m, input logic lowest);
        logic [2:0] idx;
        idx = 3'd0;
        if (lowest) begin
            for (int i = 7; i >= 0; i--) if (m[i]) idx = i[2:0];
        end else begin
            for (int i = 0; i < 8; i++) if (m[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    function automatic logic [3:0] f_code(input logic [2:0] idx, input logic stk_u);
        case (idx)
            3'd0:    return 4'hA;
            3'd1:    return 4'h8;
            3'd2:    return 4'h9;
            3'd3:    return 4'hB;
            3'd4:    return 4'h1;
            3'd5:    return 4'h2;
            3'd6:    return stk_u ? 4'h4 : 4'h3;
            default: return 4'h5;
        endcase
    endfunction

    always_comb begin
        w_idx       = f_pick(r_mask, r_pull);
        w_code      = f_code(w_idx, r_stk_u);
        w_empty     = (r_mask == 8'h00);
        w_bus_st    = (r_state == S_LO) || (r_state == S_HI) || (r_state == S_B8);
        w_byte_done = w_bus_st && bus.bus_ok;
        w_timeout   = (BUS_TO != 0) && w_bus_st && !bus.bus_ok && (r_wait == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_reg_sel   = 4'h0;
        o_wr_data   = 16'h0000;
        o_wr_en     = 1'b0;
        o_sp_out    = 16'h0000;
        o_sp_we     = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        o_err       = 1'b0;
        bus.addr    = 16'h0000;
        bus.dout    = 8'h00;
        bus.we      = 1'b0;
        bus.rd      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (w_empty) begin
                    w_state_nxt = S_FIN;
                end else begin
                    o_reg_sel   = w_code;
                    w_state_nxt = (w_idx >= 3'd4) ? (r_pull ? S_HI : S_LO) : S_B8;
                end
            end
            S_LO, S_HI, S_B8: begin
                o_reg_sel = r_sel;
                // Pushes pre-decrement, pulls post-increment; the pointer moves once per byte.
                if (r_pull) begin
                    bus.addr = r_sp;
                    bus.rd   = 1'b1;
                end else begin
                    bus.addr = r_sp - 16'd1;
                    bus.dout = (r_state == S_HI) ? i_reg_din[15:8] : i_reg_din[7:0];
                    bus.we   = 1'b1;
                end
                if (bus.bus_ok) begin
                    case (r_state)
                        S_LO:    w_state_nxt = r_pull ? S_WB : S_HI;
                        S_HI:    w_state_nxt = r_pull ? S_LO : S_NEXT;
                        default: w_state_nxt = r_pull ? S_WB : S_NEXT;
                    endcase
                end
            end
            S_WB: begin
                o_reg_sel   = r_sel;
                o_wr_en     = 1'b1;
                o_wr_data   = {r_hi, r_lo};
                w_state_nxt = S_NEXT;
            end
            S_FIN: begin
                o_sp_out    = r_sp;
                o_sp_we     = !r_err;
                o_done      = 1'b1;
                o_err       = r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                o_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_timeout) w_state_nxt = S_FIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_wait <= 16'h0000;
        end else begin
            if (r_state == S_IDLE && i_start) r_err <= 1'b0;
            if (w_timeout)                    r_err <= 1'b1;
            if (!w_bus_st || bus.bus_ok) r_wait <= 16'h0000;
            else                         r_wait <= r_wait + 16'd1;
        end
    end

`ifdef JTKCPU_PSHPUL_CNT_EN
    logic [3:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst)                               r_cnt <= 4'd0;
        else if (r_state == S_IDLE && i_start) r_cnt <= 4'd0;
        else if (w_byte_done)                  r_cnt <= r_cnt + 4'd1;
    end
    assign o_xfer_cnt = r_cnt;
`endif

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && i_start) begin
            r_mask  <= i_postbyte;
            r_pull  <= i_pull;
            r_stk_u <= i_stk_u;
            r_sp    <= i_sp_in;
        end
        if (r_state == S_NEXT && !w_empty) begin
            r_mask[w_idx] <= 1'b0;
            r_sel         <= w_code;
        end
        if (w_byte_done) begin
            r_sp <= r_pull ? r_sp + 16'd1 : r_sp - 16'd1;
            if (r_pull) begin
                if (r_state == S_HI) begin
                    r_hi <= bus.din;
                end else begin
                    r_lo <= bus.din;
                    if (r_state == S_B8) r_hi <= 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Self-checking bench for jtkcpu_pshpul: directed cases plus randomized push/pull against a stack model.
module tb_jtkcpu_pshpul;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_pull, i_stk_u;
    logic [7:0]  i_postbyte;
    logic [15:0] i_sp_in, i_reg_din, o_wr_data, o_sp_out;
    logic [3:0]  o_reg_sel;
    logic        o_wr_en, o_sp_we, o_busy, o_done, o_err;
    logic [3:0]  xfer_cnt;

    always #5 clk = ~clk;

    jtkcpu_pshpul_if ifc ();

    jtkcpu_pshpul #(.BUS_TO(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (ifc),
        .i_start    (i_start),
        .i_pull     (i_pull),
        .i_stk_u    (i_stk_u),
        .i_postbyte (i_postbyte),
        .i_sp_in    (i_sp_in),
        .o_reg_sel  (o_reg_sel),
        .i_reg_din  (i_reg_din),
        .o_wr_data  (o_wr_data),
        .o_wr_en    (o_wr_en),
        .o_sp_out   (o_sp_out),
        .o_sp_we    (o_sp_we),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
`ifdef JTKCPU_PSHPUL_CNT_EN
        ,
        .o_xfer_cnt (xfer_cnt)
`endif
    );
`ifndef JTKCPU_PSHPUL_CNT_EN
    assign xfer_cnt = 4'd0;
`endif

    logic [7:0]  mem  [0:65535];
    logic [15:0] regv [0:15];
    ev_t act_w[$], act_e[$], exp_w[$], exp_e[$];
    int  we_cnt, rd_cnt, wren_cnt, spwe_cnt;
    int  n_chk, n_fail;

    assign ifc.din   = mem[ifc.addr];
    assign i_reg_din = regv[o_reg_sel];

    // Memory and register file seen by the sequencer.
    always @(posedge clk) begin
        if (ifc.we === 1'b1) we_cnt++;
        if (ifc.rd === 1'b1) rd_cnt++;
        if (o_sp_we === 1'b1) spwe_cnt++;
        if (ifc.we === 1'b1 && ifc.bus_ok === 1'b1) begin
            mem[ifc.addr] = ifc.dout;
            act_w.push_back({ifc.addr, 8'h00, ifc.dout});
        end
        if (o_wr_en === 1'b1) begin
            wren_cnt++;
            regv[o_reg_sel] = o_wr_data;
            act_e.push_back({12'h000, o_reg_sel, o_wr_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_w(input int i);
        return (i < act_w.size()) ? act_w[i] : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] get_e(input int i);
        return (i < act_e.size()) ? act_e[i] : 32'hDEADBEEF;
    endfunction

    function automatic logic [3:0] reg_code(input int b, input logic stku);
        logic [3:0] tbl [0:7];
        tbl = '{4'hA, 4'h8, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'h5};
        if (b == 6 && stku) return 4'h4;
        return tbl[b];
    endfunction

    // Stack semantics: push stores PC first, high byte at the lower address; pull is the mirror image.
    task automatic model(input logic pull, input logic stku, input logic [7:0] pb,
                         input logic [15:0] sp_in, output logic [15:0] sp_end, output int nb);
        logic [15:0] sp, v, sp1;
        logic [3:0]  c;
        sp = sp_in;
        nb = 0;
        exp_w.delete();
        exp_e.delete();
        for (int k = 0; k < 8; k++) begin
            int b;
            b = pull ? k : 7 - k;
            if (pb[b]) begin
                c = reg_code(b, stku);
                if (!pull) begin
                    v = regv[c];
                    sp = sp - 16'd1;
                    exp_w.push_back({sp, 8'h00, v[7:0]});
                    if (b >= 4) begin
                        sp = sp - 16'd1;
                        exp_w.push_back({sp, 8'h00, v[15:8]});
                    end
                end else begin
                    sp1 = sp + 16'd1;
                    if (b >= 4) begin
                        v  = {mem[sp], mem[sp1]};
                        sp = sp + 16'd2;
                    end else begin
                        v  = {8'h00, mem[sp]};
                        sp = sp1;
                    end
                    exp_e.push_back({12'h000, c, v});
                end
                nb += (b >= 4) ? 2 : 1;
            end
        end
        sp_end = sp;
    endtask

    task automatic run_and_check(input logic pull, input logic stku, input logic [7:0] pb,
                                 input logic [15:0] sp, input bit rnd);
        logic [15:0] exp_sp, c_sp;
        logic        c_we, c_err;
        logic [3:0]  c_cnt;
        int          nb, lows;
        bit          got;
        model(pull, stku, pb, sp, exp_sp, nb);
        act_w.delete();
        act_e.delete();
        i_pull = pull; i_stk_u = stku; i_postbyte = pb; i_sp_in = sp;
        i_start = 1'b1; ifc.bus_ok = 1'b1;
        tick();
        i_start = 1'b0;
        got = 0; lows = 0; c_sp = 16'h0; c_we = 1'b0; c_err = 1'b0; c_cnt = 4'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (o_done === 1'b1) begin
                got = 1; c_sp = o_sp_out; c_we = o_sp_we; c_err = o_err; c_cnt = xfer_cnt;
                break;
            end
            if (rnd && lows < 3 && $urandom_range(0, 2) == 0) begin
                ifc.bus_ok = 1'b0; lows++;
            end else begin
                ifc.bus_ok = 1'b1; lows = 0;
            end
            tick();
        end
        ifc.bus_ok = 1'b1;
        tick();
        chk("op_done", 64'(got), 64'd1);
        chk("op_sp_out", 64'(c_sp), 64'(exp_sp));
        chk("op_sp_we", 64'(c_we), 64'd1);
        chk("op_err", 64'(c_err), 64'd0);
        chk("op_busy_after", 64'(o_busy), 64'd0);
        chk("op_nwrites", 64'(act_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++) chk("op_write", 64'(get_w(i)), 64'(exp_w[i]));
        chk("op_nregwr", 64'(act_e.size()), 64'(exp_e.size()));
        for (int i = 0; i < exp_e.size(); i++) chk("op_regwr", 64'(get_e(i)), 64'(exp_e[i]));
`ifdef JTKCPU_PSHPUL_CNT_EN
        chk("op_xfer_cnt", 64'(c_cnt), 64'(nb));
`endif
    endtask

    function automatic logic [63:0] outs_a();
        return 64'({o_reg_sel, o_wr_en, ifc.we, ifc.rd, o_sp_we, o_busy, o_done, o_err, ifc.addr, ifc.dout});
    endfunction

    function automatic logic [63:0] outs_b();
        return 64'({o_wr_data, o_sp_out, xfer_cnt});
    endfunction

    initial begin
        int cyc;
        bit got;
        n_chk = 0; n_fail = 0;
        we_cnt = 0; rd_cnt = 0; wren_cnt = 0; spwe_cnt = 0;
        rst = 1'b1; i_start = 1'b0; i_pull = 1'b0; i_stk_u = 1'b0;
        i_postbyte = 8'h00; i_sp_in = 16'h0000; ifc.bus_ok = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) regv[i] = 16'h0000;
        tick(); tick();
        chk("reset_ctrl", outs_a(), 64'd0);
        chk("reset_data", outs_b(), 64'd0);
        rst = 1'b0;
        tick();

        // PSHS PC,B,A
        regv[5] = 16'h1234; regv[9] = 16'h0022; regv[8] = 16'h0011;
        run_and_check(1'b0, 1'b0, 8'h86, 16'h1000, 1'b0);
        chk("pshs_w0", 64'(get_w(0)), 64'h0FFF_0034);
        chk("pshs_w1", 64'(get_w(1)), 64'h0FFE_0012);
        chk("pshs_w2", 64'(get_w(2)), 64'h0FFD_0022);
        chk("pshs_w3", 64'(get_w(3)), 64'h0FFC_0011);

        // PULU X,S
        mem[16'h2000] = 8'hAB; mem[16'h2001] = 8'hCD; mem[16'h2002] = 8'h12; mem[16'h2003] = 8'h34;
        run_and_check(1'b1, 1'b1, 8'h50, 16'h2000, 1'b0);
        chk("pulu_e0", 64'(get_e(0)), 64'h0001_ABCD);
        chk("pulu_e1", 64'(get_e(1)), 64'h0004_1234);

        // Wait states with stack wrap below 0x0000
        regv[8] = 16'h005A;
        act_w.delete();
        i_pull = 1'b0; i_stk_u = 1'b0; i_postbyte = 8'h02; i_sp_in = 16'h0000; i_start = 1'b1;
        tick();
        i_start = 1'b0; ifc.bus_ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) ifc.bus_ok = 1'b1;
            chk("wait_hold", 64'({ifc.addr, ifc.we, ifc.rd, ifc.dout, o_reg_sel}), 64'({16'hFFFF, 1'b1, 1'b0, 8'h5A, 4'h8}));
        end
        tick(); tick();
        chk("wait_done", 64'({o_done, o_sp_we, o_sp_out}), 64'({1'b1, 1'b1, 16'hFFFF}));
        chk("wait_mem", 64'(mem[16'hFFFF]), 64'h5A);
        tick();

        // Empty postbyte; a start while busy is ignored
        we_cnt = 0; rd_cnt = 0;
        i_postbyte = 8'h00; i_sp_in = 16'hBEEF; i_start = 1'b1;
        tick();
        i_postbyte = 8'hFF; i_sp_in = 16'h1111;
        chk("empty_next", 64'({o_busy, o_done}), 64'({1'b1, 1'b0}));
        tick();
        i_start = 1'b0;
        chk("empty_fin", 64'({o_done, o_sp_we, o_sp_out}), 64'({1'b1, 1'b1, 16'hBEEF}));
        tick();
        chk("empty_idle", 64'({o_busy, o_done}), 64'd0);
        chk("empty_nobus", 64'(we_cnt + rd_cnt), 64'd0);

        // Reset in the middle of a 16-bit pull
        mem[16'h3000] = 8'h77; mem[16'h3001] = 8'h88; regv[1] = 16'h0000;
        wren_cnt = 0; spwe_cnt = 0;
        i_pull = 1'b1; i_stk_u = 1'b0; i_postbyte = 8'h10; i_sp_in = 16'h3000; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick();
        chk("rst_mid_lo", 64'({ifc.rd, ifc.addr}), 64'({1'b1, 16'h3001}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_ctrl", outs_a(), 64'd0);
        chk("rst_mid_data", outs_b(), 64'd0);
        tick(); tick();
        chk("rst_mid_nowr", 64'({16'(wren_cnt), 16'(spwe_cnt), o_busy}), 64'd0);
        run_and_check(1'b1, 1'b0, 8'h10, 16'h3000, 1'b1);
        chk("rst_restart_x", 64'(regv[1]), 64'h7788);

        // Bus timeout with BUS_TO=4
        act_w.delete();
        i_pull = 1'b0; i_postbyte = 8'h01; i_sp_in = 16'h4000; i_start = 1'b1;
        tick();
        i_start = 1'b0; ifc.bus_ok = 1'b0;
        cyc = 0; got = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_done === 1'b1) begin got = 1; break; end
            tick(); cyc++;
        end
        chk("to_done", 64'(got), 64'd1);
        chk("to_latency", 64'(cyc), 64'd5);
        chk("to_flags", 64'({o_err, o_sp_we}), 64'({1'b1, 1'b0}));
        chk("to_nowrite", 64'(act_w.size()), 64'd0);
        ifc.bus_ok = 1'b1;
        tick();

        // Full-mask push (12 bytes), then randomized operations
        for (int c = 1; c <= 5; c++) regv[c] = 16'($urandom);
        for (int c = 8; c <= 11; c++) regv[c] = {8'h00, 8'($urandom)};
        run_and_check(1'b0, 1'b1, 8'hFF, 16'h8000, 1'b1);
        for (int k = 0; k < 40; k++) begin
            for (int c = 1; c <= 5; c++) regv[c] = 16'($urandom);
            for (int c = 8; c <= 11; c++) regv[c] = {8'h00, 8'($urandom)};
            run_and_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom), 16'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
